decode_stage: RTL

Registered, parametrised instruction-decode pipeline stage. Accepts raw instruction words over a valid/ready handshake, splits them into opcode/destination/source fields, classifies them, tags each with a sequence number and presents them downstream through a 2-entry skid buffer, so full throughput is sustained under backpressure. Sits between instruction fetch and register read/execute, replacing the purely combinational field splitter.

---
 rtl/decode_stage_if.sv | 41 ++++
 rtl/decode_stage.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/decode_stage_if.sv
// decode_stage_if: handshake bundle around the instruction-decode stage.
//   master : upstream/downstream environment (drives in_valid, in_instr, out_ready)
//   slave  : the decode stage itself (drives in_ready, decoded outputs, illegal status)
// Signals:
//   in_valid/in_ready/in_instr          upstream valid/ready with {opcode, dest, src}
//   out_valid/out_ready                 downstream valid/ready
//   out_opcode/out_dest/out_src/out_wr  decoded fields, write-enable (0 only for NOP)
//   out_seq                             sequence tag
//   illegal_flag/illegal_cnt            sticky flag and saturating count of illegal opcodes
interface decode_stage_if #(
    parameter int unsigned OPC_W = 4,
    parameter int unsigned REG_W = 3,
    parameter int unsigned SEQ_W = 4
);
    localparam int unsigned INSTR_W = OPC_W + 2 * REG_W;

    logic               in_valid;
    logic               in_ready;
    logic [INSTR_W-1:0] in_instr;
    logic               out_valid;
    logic               out_ready;
    logic [OPC_W-1:0]   out_opcode;
    logic [REG_W-1:0]   out_dest;
    logic [REG_W-1:0]   out_src;
    logic               out_wr;
    logic [SEQ_W-1:0]   out_seq;
    logic               illegal_flag;
    logic [7:0]         illegal_cnt;

    modport master (
        output in_valid, in_instr, out_ready,
        input  in_ready, out_valid, out_opcode, out_dest, out_src, out_wr, out_seq,
               illegal_flag, illegal_cnt
    );

    modport slave (
        input  in_valid, in_instr, out_ready,
        output in_ready, out_valid, out_opcode, out_dest, out_src, out_wr, out_seq,
               illegal_flag, illegal_cnt
    );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: registered instruction-decode stage with a 2-entry skid buffer.
// Splits {opcode, dest, src} at acceptance, tags each word with a wrapping sequence
// number and presents it downstream; full throughput is kept under backpressure.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset (discards both stored words)
//   bus    decode_stage_if.slave (handshakes, decoded fields, illegal status)
// Optional feature: DECODE_ILLEGAL_TRAP_EN -- illegal opcodes (>= NUM_OPC) are consumed
// without being forwarded and are counted; otherwise every word is forwarded.
module decode_stage #(
    parameter int unsigned OPC_W   = 4,
    parameter int unsigned REG_W   = 3,
    parameter int unsigned NUM_OPC = 12,
    parameter int unsigned SEQ_W   = 4
) (
    input  logic           clk,
    input  logic           reset,
    decode_stage_if.slave  bus
);
    localparam int unsigned INSTR_W = OPC_W + 2 * REG_W;

    // Parameter sanity: NUM_OPC must be a non-empty subset of the opcode space.
    if (NUM_OPC == 0 || NUM_OPC > (32'd1 << OPC_W)) begin : g_bad_num_opc
        $error("decode_stage: NUM_OPC out of range for OPC_W");
    end

    typedef struct packed {
        logic [OPC_W-1:0] opcode;
        logic [REG_W-1:0] dest;
        logic [REG_W-1:0] src;
        logic             wr;
        logic [SEQ_W-1:0] seq;
    } dec_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state_q;
    dec_t             out_q;
    dec_t             skid_q;
    logic [SEQ_W-1:0] seq_q;
    logic             out_valid_q;
    logic             in_rdy_q;

    logic accept_c;
    logic deliver_c;
    logic fwd_c;
    dec_t dec_c;

    assign accept_c  = bus.in_valid && in_rdy_q;
    assign deliver_c = out_valid_q && bus.out_ready;

    // Field split and classification of the word currently offered.
    always_comb begin
        dec_c        = '0;
        dec_c.opcode = bus.in_instr[INSTR_W-1 -: OPC_W];
        dec_c.dest   = bus.in_instr[2*REG_W-1 -: REG_W];
        dec_c.src    = bus.in_instr[REG_W-1:0];
        dec_c.wr     = (dec_c.opcode != '0);
        dec_c.seq    = seq_q;
    end

`ifdef DECODE_ILLEGAL_TRAP_EN
    logic       illegal_c;
    logic       illegal_flag_q;
    logic [7:0] illegal_cnt_q;

    assign illegal_c = (32'(dec_c.opcode) >= 32'(NUM_OPC));
    // Illegal words are swallowed: accepted upstream but never enter the buffer.
    assign fwd_c     = accept_c && !illegal_c;

    // Sticky flag and saturating count of trapped words.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            illegal_flag_q <= 1'b0;
            illegal_cnt_q  <= 8'd0;
        end else if (accept_c && illegal_c) begin
            illegal_flag_q <= 1'b1;
            if (illegal_cnt_q != 8'hFF) begin
                illegal_cnt_q <= illegal_cnt_q + 8'd1;
            end
        end
    end

    assign bus.illegal_flag = illegal_flag_q;
    assign bus.illegal_cnt  = illegal_cnt_q;
`else
    assign fwd_c            = accept_c;
    assign bus.illegal_flag = 1'b0;
    assign bus.illegal_cnt  = 8'd0;
`endif

    // Skid-buffer control, storage and sequence counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= EMPTY;
            out_q       <= '0;
            skid_q      <= '0;
            seq_q       <= '0;
            out_valid_q <= 1'b0;
            in_rdy_q    <= 1'b1;
        end else begin
            if (fwd_c) begin
                seq_q <= seq_q + SEQ_W'(1);
            end
            unique case (state_q)
                EMPTY: begin
                    if (fwd_c) begin
                        out_q       <= dec_c;
                        out_valid_q <= 1'b1;
                        state_q     <= ONE;
                    end
                end
                ONE: begin
                    if (fwd_c && !deliver_c) begin
                        skid_q   <= dec_c;
                        in_rdy_q <= 1'b0;
                        state_q  <= FULL;
                    end else if (fwd_c) begin
                        out_q <= dec_c;
                    end else if (deliver_c) begin
                        out_valid_q <= 1'b0;
                        state_q     <= EMPTY;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only a deliver can happen.
                    if (deliver_c) begin
                        out_q    <= skid_q;
                        in_rdy_q <= 1'b1;
                        state_q  <= ONE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_rdy_q    <= 1'b1;
                    state_q     <= EMPTY;
                end
            endcase
        end
    end

    // in_ready comes from a register; it is only forced low while reset is held.
    assign bus.in_ready   = in_rdy_q && !reset;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_opcode = out_q.opcode;
    assign bus.out_dest   = out_q.dest;
    assign bus.out_src    = out_q.src;
    assign bus.out_wr     = out_q.wr;
    assign bus.out_seq    = out_q.seq;

endmodule
